// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_frontend_sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous level, resetting to 1 (idle line).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: rx synchroniser, 8N1 deframer, one-entry valid/ready holding register.
// Defining UART_RX_PARITY_EN switches to 8E1 framing and adds the parity_err pulse output.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rxs;
  logic [TW-1:0]        tick;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_clr, shift_en, stop_eval, byte_ok, deliver;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_en, par_bit;
  assign byte_ok = ~^{shreg, par_bit};
`else
  assign byte_ok = 1'b1;
`endif

  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    shift_en   = 1'b0;
    stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    if (!ena) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (!rxs) begin
          state_next = START;
          tick_clr   = 1'b1;
        end
        START: if (tick == TICK_MID) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            tick_clr   = 1'b1;
          end
        end
        DATA: if (tick == TICK_LAST) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == LAST_BIT) state_next = PARITY;
`else
          if (bit_cnt == LAST_BIT) state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick == TICK_LAST) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
`endif
        STOP: if (tick == TICK_LAST) begin
          stop_eval  = 1'b1;
          state_next = rxs ? IDLE : BREAK;
        end
        // a held-low line must return high before a new start is accepted
        BREAK: if (rxs) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= state_next;
      if (tick_clr || tick == TICK_LAST) tick <= '0;
      else                               tick <= tick + 1'b1;
      if (tick_clr)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end
  end

  assign deliver = stop_eval && rxs && byte_ok;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_eval && !rxs;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rxs;
      parity_err <= stop_eval && rxs && !byte_ok;
    end
  end
`endif

endmodule
